// File: rtl/imm_pkg.sv
// Shared types for the immediate-decode stage: format codes, opcodes, stored entry.
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6
    } fmt_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_OP32   = 7'b0111011;

    // Entries are stored at the widest legal XLEN; narrower builds zero-extend.
    localparam int XLEN_MAX = 64;

    typedef struct packed {
        logic [31:0]         instr;
        logic [XLEN_MAX-1:0] pc;
        logic [XLEN_MAX-1:0] imm;
        fmt_e                fmt;
        logic [XLEN_MAX-1:0] target;
        logic                illegal;
    } entry_t;

endpackage

// File: rtl/imm_decode_stage_extract.sv
// Purpose: combinational decode of one instruction to {imm, fmt, target, illegal}; IMM_DECODE_ZICSR_EN adds format Z.
// Latency: none (pure combinational).
// Backpressure: none; the caller owns all handshaking.
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] imm,
    output fmt_e            fmt,
    output logic [XLEN-1:0] target,
    output logic            illegal
);

    always_comb begin
        fmt     = FMT_NONE;
        illegal = 1'b0;
        imm     = '0;
        target  = '0;

        if (instr[1:0] != 2'b11) begin
            illegal = 1'b1;
        end else begin
            case (instr[6:0])
                OP_LOAD, OP_IMM, OP_JALR: fmt = FMT_I;
                OP_IMM32:                 if (XLEN == 64) fmt = FMT_I; else illegal = 1'b1;
                OP_STORE:                 fmt = FMT_S;
                OP_BRANCH:                fmt = FMT_B;
                OP_LUI, OP_AUIPC:         fmt = FMT_U;
                OP_JAL:                   fmt = FMT_J;
                OP_OP, OP_FENCE:          fmt = FMT_NONE;
                OP_OP32:                  if (XLEN != 64) illegal = 1'b1;
                OP_SYSTEM: begin
`ifdef IMM_DECODE_ZICSR_EN
                    if (instr[14:12] != 3'b000) fmt = FMT_Z;
`else
                    fmt = FMT_NONE;
`endif
                end
                default:                  illegal = 1'b1;
            endcase
        end

        case (fmt)
            FMT_I: imm = XLEN'($signed(instr[31:20]));
            FMT_S: imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            FMT_B: imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
            FMT_U: imm = XLEN'($signed({instr[31:12], 12'b0}));
            FMT_J: imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
            // funct3[2] selects the 5-bit zimm form over the CSR address.
            FMT_Z: imm = instr[14] ? XLEN'(instr[19:15]) : XLEN'(instr[31:20]);
            default: imm = '0;
        endcase

        // JALR needs rs1, so only pc-relative forms get a target.
        if (fmt == FMT_B || fmt == FMT_J || (fmt == FMT_U && instr[6:0] == OP_AUIPC)) begin
            target = pc + imm;
        end
    end

endmodule

// File: rtl/imm_decode_stage.sv
// Purpose: registered immediate-decode stage with a 2-entry skid buffer (M drives outputs, K holds overflow).
// Latency: 1 cycle from accept to out_valid; 1 entry/cycle while out_ready is high.
// Backpressure: in_ready drops only when K is full; it never depends combinationally on out_ready.
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_target,
    output logic            out_illegal
);

    logic [XLEN-1:0] dec_imm;
    logic [XLEN-1:0] dec_target;
    fmt_e            dec_fmt;
    logic            dec_illegal;
    entry_t          in_entry;

    entry_t m_q, m_d, k_q, k_d;
    logic   m_vld_q, m_vld_d, k_vld_q, k_vld_d;
    logic   accept, drain;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .instr   (in_instr),
        .pc      (in_pc),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .target  (dec_target),
        .illegal (dec_illegal)
    );

    always_comb begin
        in_entry         = '0;
        in_entry.instr   = in_instr;
        in_entry.pc      = XLEN_MAX'(in_pc);
        in_entry.imm     = XLEN_MAX'(dec_imm);
        in_entry.fmt     = dec_fmt;
        in_entry.target  = XLEN_MAX'(dec_target);
        in_entry.illegal = dec_illegal;
    end

    assign in_ready = rst_n && !flush && !k_vld_q;
    assign accept   = in_valid && in_ready;
    assign drain    = m_vld_q && out_ready;

    always_comb begin
        m_d     = m_q;
        k_d     = k_q;
        m_vld_d = m_vld_q;
        k_vld_d = k_vld_q;

        if (flush) begin
            m_vld_d = 1'b0;
            k_vld_d = 1'b0;
        end else if (drain && k_vld_q) begin
            // accept is impossible here: in_ready is low whenever K is full.
            m_d     = k_q;
            k_vld_d = 1'b0;
        end else if (drain) begin
            m_vld_d = accept;
            if (accept) m_d = in_entry;
        end else if (accept) begin
            if (!m_vld_q) begin
                m_d     = in_entry;
                m_vld_d = 1'b1;
            end else begin
                k_d     = in_entry;
                k_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_q     <= '0;
            k_q     <= '0;
            m_vld_q <= 1'b0;
            k_vld_q <= 1'b0;
        end else begin
            m_q     <= m_d;
            k_q     <= k_d;
            m_vld_q <= m_vld_d;
            k_vld_q <= k_vld_d;
        end
    end

    assign out_valid   = m_vld_q;
    assign out_instr   = m_q.instr;
    assign out_pc      = m_q.pc[XLEN-1:0];
    assign out_imm     = m_q.imm[XLEN-1:0];
    assign out_fmt     = m_q.fmt;
    assign out_target  = m_q.target[XLEN-1:0];
    assign out_illegal = m_q.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Scoreboard bench for imm_decode_stage: reference model pushes expectations, monitor pops on each drain.
module tb_imm_decode_stage;

    localparam int XLEN = 32;
    localparam logic [63:0] MASK = (XLEN == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [31:0]     in_instr = '0;
    logic [XLEN-1:0] in_pc = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [31:0]     out_instr;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic [XLEN-1:0] out_target;
    logic            out_illegal;

    imm_decode_stage #(.XLEN(XLEN)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .out_imm     (out_imm),
        .out_fmt     (out_fmt),
        .out_target  (out_target),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [63:0] imm;
        logic [63:0] target;
        int          fmt;
        bit          illegal;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    logic [6:0] ops [0:12] = '{7'h03, 7'h13, 7'h67, 7'h1B, 7'h23, 7'h63, 7'h37,
                               7'h17, 7'h6F, 7'h33, 7'h0F, 7'h73, 7'h3B};

    function automatic longint sx(input longint v, input int bits);
        longint half;
        half = longint'(1) << (bits - 1);
        return (v >= half) ? v - (half << 1) : v;
    endfunction

    function automatic exp_t model(input logic [31:0] ins, input logic [63:0] pc);
        exp_t   e;
        longint w;
        longint imm;
        longint f3;
        w   = longint'(ins);
        imm = 0;
        e.instr = ins; e.pc = pc & MASK; e.fmt = 0; e.illegal = 1'b0;
        if (ins[1:0] != 2'b11) begin
            e.illegal = 1'b1;
        end else begin
            case (ins[6:0])
                7'h03, 7'h13, 7'h67: begin e.fmt = 1; imm = sx(w >> 20, 12); end
                7'h1B: if (XLEN == 64) begin e.fmt = 1; imm = sx(w >> 20, 12); end
                       else e.illegal = 1'b1;
                7'h23: begin e.fmt = 2; imm = sx(((w >> 25) << 5) + ((w >> 7) & 31), 12); end
                7'h63: begin
                    e.fmt = 3;
                    imm = sx(((w >> 31) & 1) * 4096 + ((w >> 7) & 1) * 2048
                             + ((w >> 25) & 63) * 32 + ((w >> 8) & 15) * 2, 13);
                end
                7'h37, 7'h17: begin e.fmt = 4; imm = sx(w & 64'hFFFF_F000, 32); end
                7'h6F: begin
                    e.fmt = 5;
                    imm = sx(((w >> 31) & 1) * (1 << 20) + ((w >> 12) & 255) * (1 << 12)
                             + ((w >> 20) & 1) * (1 << 11) + ((w >> 21) & 1023) * 2, 21);
                end
                7'h33, 7'h0F: ;
                7'h3B: if (XLEN != 64) e.illegal = 1'b1;
                7'h73: begin
                    f3 = (w >> 12) & 7;
`ifdef IMM_DECODE_ZICSR_EN
                    if (f3 != 0) begin
                        e.fmt = 6;
                        imm = (f3 >= 4) ? ((w >> 15) & 31) : ((w >> 20) & 4095);
                    end
`endif
                end
                default: e.illegal = 1'b1;
            endcase
        end
        e.imm = imm & MASK;
        if (e.fmt == 3 || e.fmt == 5 || (e.fmt == 4 && ins[6:0] == 7'h17))
            e.target = (pc + imm) & MASK;
        else
            e.target = '0;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Presents one entry, retrying each cycle until in_ready; optional random downstream stalls.
    task automatic send(input logic [31:0] ins, input logic [XLEN-1:0] pc, input bit rnd_rdy);
        bit done;
        done = 1'b0;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            flush = 1'b0; in_valid = 1'b1; in_instr = ins; in_pc = pc;
            if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (in_ready) begin
                exp_q.push_back(model(ins, 64'(pc)));
                done = 1'b1;
            end
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL send_timeout: in_ready stuck low for instr %h", ins);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 9))
            0: ;
            1: r[1:0] = 2'($urandom_range(0, 2));
            default: r[6:0] = ops[$urandom_range(0, 12)];
        endcase
        return r;
    endfunction

    // Monitor: every transfer out of the stage must match the oldest expectation.
    initial begin
        exp_t e;
        bit   ok;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && !flush && out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_out: instr %h with empty scoreboard", out_instr);
                end else begin
                    e = exp_q.pop_front();
                    ok = (out_instr == e.instr) && (64'(out_pc) == e.pc) && (64'(out_imm) == e.imm)
                         && (int'(out_fmt) == e.fmt) && (64'(out_target) == e.target)
                         && (out_illegal == e.illegal);
                    if (!ok) begin
                        bad++;
                        $display("FAIL out_entry: got instr=%h pc=%h imm=%h fmt=%0d tgt=%h ill=%0d expected instr=%h pc=%h imm=%h fmt=%0d tgt=%h ill=%0d",
                                 out_instr, out_pc, out_imm, out_fmt, out_target, out_illegal,
                                 e.instr, e.pc, e.imm, e.fmt, e.target, e.illegal);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_imm", 64'(out_imm), 64'd0);
        chk("rst_out_target", 64'(out_target), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Directed decodes with 1-cycle latency check on the first
        out_ready = 1'b1;
        send(32'hFFF00093, '0, 1'b0);
        idle();
        #1;
        chk("latency_out_valid", 64'(out_valid), 64'd1);
        chk("addi_imm", 64'(out_imm), 64'hFFFF_FFFF & MASK);
        send(32'hFE000EE3, XLEN'(32'h100), 1'b0);
        send(32'h0080006F, XLEN'(32'hFFFF_FFFC), 1'b0);
        send(32'h3002D073, XLEN'(32'h40), 1'b0);
        send(32'h00000000, XLEN'(32'h44), 1'b0);
        idle();
        idle();

        // Capacity: A into M, B into K, C held off
        out_ready = 1'b0;
        send(32'h00500113, XLEN'(32'h200), 1'b0);
        send(32'h00600193, XLEN'(32'h204), 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_instr = 32'h00700213; in_pc = XLEN'(32'h208);
            #1;
            chk("full_in_ready", 64'(in_ready), 64'd0);
            chk("full_out_instr_stable", 64'(out_instr), 64'h00500113);
        end
        out_ready = 1'b1;
        send(32'h00700213, XLEN'(32'h208), 1'b0);
        idle();
        idle();
        idle();
        chk("capacity_drained", 64'(exp_q.size()), 64'd0);

        // Flush with M and K full and a simultaneous input
        out_ready = 1'b0;
        send(32'h00800293, XLEN'(32'h300), 1'b0);
        send(32'h00900313, XLEN'(32'h304), 1'b0);
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; in_instr = 32'h00A00393; in_pc = XLEN'(32'h308);
        #1;
        chk("flush_in_ready", 64'(in_ready), 64'd0);
        exp_q.delete();
        idle();
        #1;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready_after", 64'(in_ready), 64'd1);
        idle();
        #1;
        chk("flush_input_dropped", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        send(32'h00000000, XLEN'(32'h30C), 1'b0);
        idle();
        #1;
        chk("illegal_flag", 64'(out_illegal), 64'd1);
        chk("illegal_fmt", 64'(out_fmt), 64'd0);
        idle();

        // Reset mid-operation discards both entries
        out_ready = 1'b0;
        send(32'h00B00413, XLEN'(32'h400), 1'b0);
        send(32'h00C00493, XLEN'(32'h404), 1'b0);
        @(negedge clk);
        in_valid = 1'b0; rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);

        // Randomized traffic with stalls and occasional flushes
        for (int it = 0; it < 400; it++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r == 0) begin
                @(negedge clk);
                flush = 1'b1;
                in_valid = $urandom_range(0, 1);
                in_instr = rand_instr();
                #1;
                chk("rnd_flush_in_ready", 64'(in_ready), 64'd0);
                exp_q.delete();
            end else if (r < 14) begin
                send(rand_instr(), XLEN'($urandom), 1'b1);
            end else begin
                idle();
                out_ready = ($urandom_range(0, 1) != 0);
            end
        end
        idle();
        out_ready = 1'b1;
        repeat (5) idle();
        chk("final_scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imm_decode_stage.md
# imm_decode_stage

Registered, parametrised immediate-decode stage between instruction fetch and the register-read/execute stage. Accepts one 32-bit instruction plus its PC per valid/ready handshake and decodes all base RISC-V immediate formats (I/S/B/U/J) for XLEN 32 or 64. It flags illegal or unknown opcodes and precomputes the PC-relative target for branches, JAL and AUIPC. A 2-entry skid buffer sustains full throughput under backpressure, and a flush input supports redirects.

## Interface
- `XLEN`, 32, datapath width; legal values are 32 and 64.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `flush` input 1: drop all buffered entries.
- `in_valid` input 1: upstream entry valid.
- `in_ready` output 1: stage can accept an entry.
- `in_instr` input 32: raw instruction.
- `in_pc` input XLEN: instruction address.
- `out_valid` output 1: decoded entry valid.
- `out_ready` input 1: downstream accepts.
- `out_instr` output 32: instruction, passed through.
- `out_pc` output XLEN: PC, passed through.
- `out_imm` output XLEN: decoded immediate.
- `out_fmt` output 3: format code (see Structure).
- `out_target` output XLEN: `pc + imm` for B/J/AUIPC, otherwise 0.
- `out_illegal` output 1: unknown opcode or `instr[1:0] != 2'b11`.

## Operation
- Decode by `instr[6:0]`:
  - I: 0000011, 0010011, 1100111; 0011011 only when XLEN=64.
  - S: 0100011. B: 1100011. U: 0110111, 0010111. J: 1101111.
  - NONE, legal: 0110011, 0001111, 1110011; 0111011 only when XLEN=64.
  - Any other opcode, or `instr[1:0] != 2'b11`: NONE, illegal. For illegal entries `out_imm=0` and `out_target=0`.
- Immediates are sign-extended from `instr[31]` to XLEN. B and J have bit 0 forced to 0. U is `{instr[31:12],12'b0}` sign-extended (matters for XLEN=64).
- Target arithmetic is modulo 2^XLEN; wrap-around is silent. JALR gets no target because it needs rs1.
- Skid buffer: main register M feeds the outputs; skid register K holds overflow.
  - Accept occurs when `in_valid && in_ready`.
  - M is loaded when it is empty or being drained (`out_valid && out_ready`); otherwise the entry goes to K.
  - When M drains and K is full, K moves to M in the same cycle.
  - Order is strictly FIFO; no loss, no duplication.
- `in_ready = rst_n && !flush && !K_valid`. It is derived from registered state only, never combinationally from `out_ready`.
- `flush=1`: M and K are invalidated at the next edge, and any input in that cycle is not accepted. `flush` has priority over simultaneous accept and drain.

## Timing
- Reset (`rst_n` low at an edge): `out_valid=0`, `K_valid=0`, all data outputs 0. `in_ready` is 0 while `rst_n` is low and 1 in the first cycle after release.
- Latency: accept at edge N gives `out_valid=1` after edge N with decoded fields, i.e. 1 cycle.
- Throughput: 1 entry/cycle while `out_ready=1`.
- Capacity: 2 entries. With `out_ready` held low, the 2nd accept fills K and `in_ready` drops in the following cycle.
- Output fields stay stable while `out_valid && !out_ready`.
- Reset mid-operation discards both entries; nothing is replayed.

## Configuration
- Macro: `IMM_DECODE_ZICSR_EN`.
- Defined: opcode 1110011 with `funct3 != 000` decodes as format Z.
  - `funct3[2]=1`: `out_imm` = zero-extended `instr[19:15]` (zimm).
  - `funct3[2]=0`: `out_imm` = zero-extended `instr[31:20]` (CSR address).
  - `funct3=000` remains NONE.
- Undefined: all of opcode 1110011 is NONE, legal, `out_imm=0`, and code 6 is never produced.

## Structure
- Package `imm_pkg`:
  - Format codes: NONE=0, I=1, S=2, B=3, U=4, J=5, Z=6.
  - Opcode constants.
  - Entry struct {instr, pc, imm, fmt, target, illegal}.
- Sub-module `imm_extract`: purely combinational decode of one instruction to {imm, fmt, target, illegal}, parametrised by XLEN.
  - Instantiated once on the input side, so M and K store decoded entries.
  - The top level holds only the skid/handshake logic.

## Test plan
- Decode: 0xFFF00093 (addi -1), pc=0 → `out_imm=0xFFFFFFFF`, `fmt=1`, `target=0`, one cycle after accept.
- Branch: 0xFE000EE3 (beq -4) at pc=0x100 → `imm=0xFFFFFFFC`, `fmt=3`, `target=0x000000FC`.
- Wrap: 0x0080006F (jal +8) at pc=0xFFFFFFFC → `imm=8`, `fmt=5`, `target=0x00000004`.
- Backpressure: `out_ready=0`, push A,B,C back-to-back → A,B accepted, `in_ready=0` while C is held. Then `out_ready=1` → A,B,C emerge in order, each exactly once.
- Flush/illegal: with M and K full, assert `flush` alongside `in_valid` → next cycle `out_valid=0`, `in_ready=1`, and the input is not taken. Then 0x00000000 → `out_illegal=1`, `fmt=0`, `imm=0`.
- CSR: 0x3002D073 (csrrwi 0x300, 5) → with `IMM_DECODE_ZICSR_EN`: `fmt=6`, `imm=5`. Without it: `fmt=0`, `out_illegal=0`.
